temp_sampler: RTL and testbench

Front-end stage feeding `air_conditioning`: periodically requests a conversion from a serial temperature sensor, deserialises the 8-bit reading, and runs a power-of-two moving average over recent frames. It then saturates the result to the 5-bit `temperature` bus consumed by the controller. It also flags sensor timeouts and error codes so the controller never acts on a corrupt reading.

---
 rtl/ac_pkg.sv | 24 ++
 rtl/temp_avg.sv | 72 +++++++
 rtl/temp_sampler.sv | 114 +++++++++++
 tb/tb_temp_sampler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ac_pkg.sv
// Shared constants and types for the air-conditioning control chain:
// sensor frame format, temperature bus range and controller thresholds.
package ac_pkg;

   localparam int             FRAME_W         = 8;
   localparam int             TEMP_W          = 5;
   localparam logic [4:0]     TEMP_MAX        = 5'd31;
   localparam logic [4:0]     RESET_TEMP      = 5'd20;
   localparam logic [7:0]     SENSOR_ERR_CODE = 8'hFF;

   // Thresholds used by air_conditioning; RESET_TEMP sits inside its idle band.
   localparam logic [4:0]     TEMP_LOW        = 5'd18;
   localparam logic [4:0]     TEMP_MID        = 5'd20;
   localparam logic [4:0]     TEMP_HIGH       = 5'd22;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      RECV,
      ACC,
      OUT
   } state_e;

endpackage

// File: rtl/temp_avg.sv
// Power-of-two moving average over sensor frames with prime-on-first-sample
// and saturation to the temperature bus range.
module temp_avg
   import ac_pkg::*;
#(
   parameter int AVG_LOG2 = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_load,
   input  logic [FRAME_W-1:0] i_sample,
   output logic [TEMP_W-1:0]  o_temp
);

   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int SUM_W = FRAME_W + AVG_LOG2;
   localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

   logic [FRAME_W-1:0] r_buf [DEPTH];
   logic [SUM_W-1:0]   r_sum;
   logic [PTR_W-1:0]   r_wp;
   logic               r_prime;
   logic [TEMP_W-1:0]  r_temp;

   logic [SUM_W-1:0]   w_sum_next;
   logic [SUM_W-1:0]   w_avg;

   function automatic logic [TEMP_W-1:0] sat_temp(input logic [SUM_W-1:0] v);
      if (v > SUM_W'(TEMP_MAX)) begin
         return TEMP_MAX;
      end
      return v[TEMP_W-1:0];
   endfunction

   // The first good frame seeds the whole window so the output never ramps up from zero.
   always_comb begin
      w_sum_next = r_sum;
      if (r_prime) begin
         w_sum_next = SUM_W'(i_sample) << AVG_LOG2;
      end else begin
         w_sum_next = r_sum - SUM_W'(r_buf[r_wp]) + SUM_W'(i_sample);
      end
      w_avg = w_sum_next >> AVG_LOG2;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_buf[i] <= '0;
         end
         r_sum   <= '0;
         r_wp    <= '0;
         r_prime <= 1'b1;
         r_temp  <= RESET_TEMP;
      end else if (i_load) begin
         if (r_prime) begin
            for (int i = 0; i < DEPTH; i++) begin
               r_buf[i] <= i_sample;
            end
         end else begin
            r_buf[r_wp] <= i_sample;
         end
         r_sum   <= w_sum_next;
         r_wp    <= (AVG_LOG2 == 0) ? '0 : r_wp + PTR_W'(1);
         r_prime <= 1'b0;
         r_temp  <= sat_temp(w_avg);
      end
   end

   assign o_temp = r_temp;

endmodule

// File: rtl/temp_sampler.sv
// Periodic serial temperature sensor front-end: requests conversions,
// deserialises 8-bit frames, filters them and flags sensor failures.
module temp_sampler
   import ac_pkg::*;
#(
   parameter int SAMPLE_PERIOD = 100,
   parameter int TIMEOUT       = 32,
   parameter int AVG_LOG2      = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              conv_req,
   input  logic              s_bit_valid,
   input  logic              s_bit,
   output logic [TEMP_W-1:0] temperature,
   output logic              temp_valid,
   output logic              sensor_err
);

   localparam int PCNT_W = $clog2(SAMPLE_PERIOD);
   localparam int TCNT_W = $clog2(TIMEOUT);

   state_e             r_state;
   logic [PCNT_W-1:0]  r_pcnt;
   logic [TCNT_W-1:0]  r_tcnt;
   logic [2:0]         r_bcnt;
   logic [FRAME_W-1:0] r_frame;
   logic               r_err;

   logic               w_wrap;
   logic               w_load;
   logic [TEMP_W-1:0]  w_temp;

   assign w_wrap = (r_pcnt == PCNT_W'(SAMPLE_PERIOD - 1));
   assign w_load = (r_state == ACC) && (r_frame != SENSOR_ERR_CODE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pcnt <= '0;
      end else begin
         r_pcnt <= w_wrap ? '0 : r_pcnt + PCNT_W'(1);
      end
   end

   // A wrap that finds the FSM busy is simply lost; requests never queue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_tcnt  <= '0;
         r_bcnt  <= '0;
         r_frame <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_wrap) begin
                  r_state <= REQ;
               end
            end
            REQ: begin
               r_tcnt  <= '0;
               r_bcnt  <= '0;
               r_state <= RECV;
            end
            RECV: begin
               if (s_bit_valid) begin
                  r_frame <= {r_frame[FRAME_W-2:0], s_bit};
                  r_tcnt  <= '0;
                  r_bcnt  <= r_bcnt + 3'd1;
                  if (r_bcnt == 3'd7) begin
                     r_state <= ACC;
                  end
               end else if (r_tcnt == TCNT_W'(TIMEOUT - 1)) begin
                  r_err   <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_tcnt <= r_tcnt + TCNT_W'(1);
               end
            end
            ACC: begin
               if (r_frame == SENSOR_ERR_CODE) begin
                  r_err   <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_err   <= 1'b0;
                  r_state <= OUT;
               end
            end
            OUT: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   temp_avg #(
      .AVG_LOG2 (AVG_LOG2)
   ) u_avg (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_load),
      .i_sample (r_frame),
      .o_temp   (w_temp)
   );

   assign conv_req    = (r_state == REQ);
   assign temp_valid  = (r_state == OUT);
   assign sensor_err  = r_err;
   assign temperature = w_temp;

endmodule

// File: tb/tb_temp_sampler.sv
// Scoreboard bench for temp_sampler: expected temperatures are queued as
// frames are sent and compared whenever temp_valid pulses.
module tb_temp_sampler;

   localparam int SAMPLE_PERIOD = 100;
   localparam int TIMEOUT       = 32;
   localparam int AVG_LOG2      = 2;
   localparam int DEPTH         = 1 << AVG_LOG2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       s_bit_valid = 1'b0;
   logic       s_bit = 1'b0;
   logic       conv_req;
   logic       temp_valid;
   logic       sensor_err;
   logic [4:0] temperature;

   int n_chk = 0;
   int n_fail = 0;
   int exp_q[$];

   int m_buf[DEPTH];
   int m_wp;
   bit m_prime;
   int m_temp;

   always #5 clk = ~clk;

   temp_sampler #(
      .SAMPLE_PERIOD (SAMPLE_PERIOD),
      .TIMEOUT       (TIMEOUT),
      .AVG_LOG2      (AVG_LOG2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .conv_req    (conv_req),
      .s_bit_valid (s_bit_valid),
      .s_bit       (s_bit),
      .temperature (temperature),
      .temp_valid  (temp_valid),
      .sensor_err  (sensor_err)
   );

   task automatic chk_val(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_prime = 1'b1;
      m_wp    = 0;
      m_temp  = 20;
      foreach (m_buf[i]) m_buf[i] = 0;
   endtask

   function automatic int model_push(input int s);
      int sum;
      int avg;
      if (m_prime) begin
         foreach (m_buf[i]) m_buf[i] = s;
         m_prime = 1'b0;
         m_wp    = 0;
      end else begin
         m_buf[m_wp] = s;
         m_wp = (m_wp + 1) % DEPTH;
      end
      sum = 0;
      foreach (m_buf[i]) sum += m_buf[i];
      avg = sum / DEPTH;
      return (avg > 31) ? 31 : avg;
   endfunction

   // Scoreboard: every temp_valid pulse consumes one queued expectation.
   always @(negedge clk) begin
      if (rst_n && temp_valid) begin
         if (exp_q.size() == 0) begin
            chk_val("tv_unexpected", int'(temp_valid), 0);
         end else begin
            chk_val("temp_out", int'(temperature), exp_q.pop_front());
         end
      end
   end

   // Returns #1 after the edge that enters RECV, so bits can be driven at once.
   task automatic do_req();
      int found;
      found = 0;
      for (int i = 0; i < 2 * SAMPLE_PERIOD; i++) begin
         @(posedge clk); #1;
         if (conv_req) begin
            found = 1;
            break;
         end
      end
      chk_val("req_seen", found, 1);
      @(posedge clk); #1;
   endtask

   task automatic send_bits(input logic [7:0] v, input int nbits, input int gap_at, input int gap_len);
      for (int i = 0; i < nbits; i++) begin
         if (i == gap_at) begin
            s_bit_valid = 1'b0;
            repeat (gap_len) @(posedge clk);
            #1;
         end
         s_bit_valid = 1'b1;
         s_bit       = v[7-i];
         @(posedge clk); #1;
      end
      s_bit_valid = 1'b0;
      s_bit       = 1'b0;
   endtask

   task automatic frame_body(input logic [7:0] v, input int gap_at, input int gap_len);
      int e;
      e = model_push(int'(v));
      exp_q.push_back(e);
      m_temp = e;
      send_bits(v, 8, gap_at, gap_len);
      chk_val("tv_early", int'(temp_valid), 0);
      @(posedge clk); #1;
      chk_val("tv_latency", int'(temp_valid), 1);
      chk_val("err_clear", int'(sensor_err), 0);
      chk_val("temp_reg", int'(temperature), e);
      @(posedge clk); #1;
      chk_val("tv_pulse_w", int'(temp_valid), 0);
   endtask

   task automatic good_frame(input logic [7:0] v, input int gap_at, input int gap_len);
      do_req();
      frame_body(v, gap_at, gap_len);
   endtask

   initial begin
      int cyc;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_val("rst_temp", int'(temperature), 20);
      chk_val("rst_tv", int'(temp_valid), 0);
      chk_val("rst_err", int'(sensor_err), 0);
      chk_val("rst_req", int'(conv_req), 0);

      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      for (int i = 1; i <= 2 * SAMPLE_PERIOD; i++) begin
         @(posedge clk); #1;
         if (conv_req) begin
            cyc = i;
            break;
         end
      end
      chk_val("req1_cycle", cyc, SAMPLE_PERIOD);
      @(posedge clk); #1;
      chk_val("req_one_cycle", int'(conv_req), 0);
      cyc = 0;
      for (int i = 2; i <= 2 * SAMPLE_PERIOD; i++) begin
         @(posedge clk); #1;
         if (conv_req) begin
            cyc = i;
            break;
         end
      end
      chk_val("req2_cycle", cyc, SAMPLE_PERIOD);
      chk_val("err_empty_frame", int'(sensor_err), 1);
      chk_val("temp_after_to", int'(temperature), 20);
      @(posedge clk); #1;

      frame_body(8'd18, -1, 0);
      good_frame(8'd22, -1, 0);

      // Partial frame: five bits, then silence until the timeout fires.
      do_req();
      send_bits(8'h55, 5, -1, 0);
      repeat (TIMEOUT - 1) @(posedge clk);
      #1;
      chk_val("err_before_to", int'(sensor_err), 0);
      @(posedge clk); #1;
      chk_val("err_at_to", int'(sensor_err), 1);
      chk_val("temp_hold_to", int'(temperature), m_temp);

      good_frame(8'd20, -1, 0);

      do_req();
      send_bits(8'hFF, 8, -1, 0);
      @(posedge clk); #1;
      chk_val("ff_tv_acc", int'(temp_valid), 0);
      @(posedge clk); #1;
      chk_val("ff_err", int'(sensor_err), 1);
      chk_val("ff_tv", int'(temp_valid), 0);
      chk_val("ff_temp_hold", int'(temperature), m_temp);

      // Bit arrives on the last idle cycle before timeout and must be taken.
      good_frame(8'd16, 3, TIMEOUT - 1);
      good_frame(8'd200, -1, 0);

      do_req();
      send_bits(8'hA5, 4, -1, 0);
      rst_n = 1'b0;
      #1;
      chk_val("mid_rst_temp", int'(temperature), 20);
      chk_val("mid_rst_tv", int'(temp_valid), 0);
      chk_val("mid_rst_err", int'(sensor_err), 0);
      chk_val("mid_rst_req", int'(conv_req), 0);
      m_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      good_frame(8'd25, -1, 0);
      good_frame(8'd9, -1, 0);

      repeat (3) @(posedge clk);
      #1;
      chk_val("q_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
